// File: rtl/op_access_sequencer.sv
// Sequences the data-memory or VGA access of the instruction in execute and holds the datapath meanwhile.
// Latency: done N+2 cycles after the start edge (N = ack/ready delay), 1 cycle for ALU-only, TIMEOUT+1 on abort.
// Backpressure: stall holds the datapath while busy; mem_req / vga strobes are held until mem_ack / vga_ready.
module op_access_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  read,
    input  logic                  write,
    input  logic                  print,
    input  logic                  flip,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  vga_ready,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  vga_print,
    output logic                  vga_flip,
    output logic [ADDR_WIDTH-1:0] vga_addr,
    output logic [DATA_WIDTH-1:0] vga_data,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rdata_valid,
    output logic                  stall,
    output logic                  done,
    output logic                  err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MEM  = 2'd1;
    localparam logic [1:0] VGA  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    logic [1:0] state;
    logic [7:0] wait_cnt;
    logic       op_we;
    logic       op_print;
    logic       op_flip;

    logic any_strobe;
    logic multi_strobe;
    logic wait_hit;
    logic timeout_hit;

    always_comb begin
        any_strobe   = read | write | print | flip;
        multi_strobe = (read & (write | print | flip)) | (write & (print | flip)) | (print & flip);
        wait_hit     = ((state == MEM) & mem_ack) | ((state == VGA) & vga_ready);
        // Abort on the cycle whose increment would reach TIMEOUT; a same-cycle ack takes precedence.
        timeout_hit  = !wait_hit && ((wait_cnt + 8'd1) == TMO);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= 8'd0;
            op_we     <= 1'b0;
            op_print  <= 1'b0;
            op_flip   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            vga_addr  <= '0;
            vga_data  <= '0;
            rdata     <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wait_cnt <= 8'd0;
                    if (start) begin
                        if (multi_strobe) begin
                            err <= 1'b1;
                        end
                        if (read || write) begin
                            state     <= MEM;
                            op_we     <= !read;
                            mem_addr  <= addr;
                            mem_wdata <= wdata;
                        end else if (print || flip) begin
                            state    <= VGA;
                            op_print <= print;
                            op_flip  <= !print;
                            vga_addr <= addr;
                            vga_data <= wdata;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                MEM, VGA: begin
                    if (wait_hit) begin
                        state <= DONE;
                        if ((state == MEM) && !op_we) begin
                            rdata <= mem_rdata;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if (timeout_hit) begin
                            err   <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        mem_req     = (state == MEM);
        mem_we      = (state == MEM) & op_we;
        vga_print   = (state == VGA) & op_print;
        vga_flip    = (state == VGA) & op_flip;
        // Flags the edge at which rdata loads, i.e. the cycle before done.
        rdata_valid = (state == MEM) & mem_ack & !op_we;
        done        = (state == DONE);
        stall       = ((state == IDLE) & start & any_strobe) | (state == MEM) | (state == VGA);
    end

endmodule
